// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry register file datapath.
package regfile_pkg;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/decoder_5_to_32.sv
// Write-address decoder: one-hot register select, all zeros when disabled.
module decoder_5_to_32
  import regfile_pkg::*;
(
  input  logic                 ena,
  input  reg_addr_t            addr,
  output logic [REG_COUNT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (ena) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/mux32.sv
// Single-bit 32:1 read multiplexer.
module mux32
  import regfile_pkg::*;
(
  input  logic [REG_COUNT-1:0] d,
  input  reg_addr_t            sel,
  output logic                 y
);

  assign y = d[sel];

endmodule

// File: rtl/register_file.sv
// 32 x N register file, one synchronous write port, two combinational read ports, x0 hardwired to zero.
// Optional write-to-read forwarding is built when REGISTER_FILE_BYPASS_EN is defined.
module register_file
  import regfile_pkg::*;
#(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_ena,
  input  reg_addr_t       wr_addr,
  input  logic [N-1:0]    wr_data,
  input  reg_addr_t       rd_addr0,
  output logic [N-1:0]    rd_data0,
  input  reg_addr_t       rd_addr1,
  output logic [N-1:0]    rd_data1
);

  logic [REG_COUNT-1:0] wr_sel;
  logic [N-1:0]         regs [REG_COUNT];
  logic [N-1:0]         mux0;
  logic [N-1:0]         mux1;
  logic                 unused_wr_sel0;

  decoder_5_to_32 u_dec (
    .ena    (wr_ena),
    .addr   (wr_addr),
    .onehot (wr_sel)
  );

  // x0 has no storage at all, so a write to it can never land anywhere.
  assign regs[0]        = '0;
  assign unused_wr_sel0 = wr_sel[0];

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    logic [N-1:0] q;

    always_ff @(posedge clk) begin
      if (!rst)
        q <= '0;
      else if (wr_sel[i])
        q <= wr_data;
    end

    assign regs[i] = q;
  end

  for (genvar b = 0; b < N; b++) begin : g_bit
    logic [REG_COUNT-1:0] col;

    for (genvar r = 0; r < REG_COUNT; r++) begin : g_col
      assign col[r] = regs[r][b];
    end

    mux32 u_mux0 (
      .d   (col),
      .sel (rd_addr0),
      .y   (mux0[b])
    );

    mux32 u_mux1 (
      .d   (col),
      .sel (rd_addr1),
      .y   (mux1[b])
    );
  end

`ifdef REGISTER_FILE_BYPASS_EN
  logic wr_live;
  logic fwd0;
  logic fwd1;

  // Forward only writes that will actually commit at the next edge.
  assign wr_live  = wr_ena && rst && (wr_addr != REG_ZERO);
  assign fwd0     = wr_live && (rd_addr0 == wr_addr);
  assign fwd1     = wr_live && (rd_addr1 == wr_addr);
  assign rd_data0 = fwd0 ? wr_data : mux0;
  assign rd_data1 = fwd1 ? wr_data : mux1;
`else
  assign rd_data0 = mux0;
  assign rd_data1 = mux1;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (honours REGISTER_FILE_BYPASS_EN for read-during-write).
module tb_register_file;
  import regfile_pkg::*;

  localparam int N = 32;

  logic            clk;
  logic            rst;
  logic            wr_ena;
  reg_addr_t       wr_addr;
  logic [N-1:0]    wr_data;
  reg_addr_t       rd_addr0;
  logic [N-1:0]    rd_data0;
  reg_addr_t       rd_addr1;
  logic [N-1:0]    rd_data1;

  int errors = 0;
  int checks = 0;

  register_file #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input reg_addr_t a, input logic [N-1:0] d);
    @(negedge clk);
    wr_ena  = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_ena  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < REG_COUNT; i++) begin
      rd_addr0 = reg_addr_t'(i);
      rd_addr1 = reg_addr_t'(REG_COUNT - 1 - i);
      #1;
      check($sformatf("%s_p0_r%0d", tag, i), rd_data0, '0);
      check($sformatf("%s_p1_r%0d", tag, REG_COUNT - 1 - i), rd_data1, '0);
    end
  endtask

  logic [N-1:0] rdw_exp;

  initial begin
    rst      = 1'b0;
    wr_ena   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr0 = '0;
    rd_addr1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    sweep_zero("init");

    // Reset clears a fully-written file
    for (int i = 1; i < REG_COUNT; i++) wr(reg_addr_t'(i), 32'hFFFF_FFFF);
    rd_addr0 = 5'd17;
    #1;
    check("prefill_r17", rd_data0, 32'hFFFF_FFFF);
    pulse_reset();
    sweep_zero("rst");

    // Write/read all
    for (int i = 1; i < REG_COUNT; i++) wr(reg_addr_t'(i), 32'hA5A5_0000 | i);
    for (int i = 0; i < REG_COUNT; i++) begin
      rd_addr0 = reg_addr_t'(i);
      rd_addr1 = reg_addr_t'(i);
      #1;
      check($sformatf("all_p0_r%0d", i), rd_data0, (i == 0) ? 32'h0 : (32'hA5A5_0000 | i));
      check($sformatf("all_p1_r%0d", i), rd_data1, (i == 0) ? 32'h0 : (32'hA5A5_0000 | i));
    end

    // x0 immutability
    wr(5'd0, 32'hDEAD_BEEF);
    rd_addr0 = 5'd0;
    rd_addr1 = 5'd0;
    #1;
    check("x0_p0", rd_data0, 32'h0);
    check("x0_p1", rd_data1, 32'h0);

    // wr_ena gating
    wr(5'd5, 32'h1234_5678);
    @(negedge clk);
    wr_ena  = 1'b0;
    wr_addr = 5'd5;
    wr_data = 32'h0;
    @(posedge clk);
    #1;
    rd_addr0 = 5'd5;
    #1;
    check("gate_r5", rd_data0, 32'h1234_5678);

    // Dual port independence
    wr(5'd3, 32'h3);
    wr(5'd7, 32'h7);
    rd_addr0 = 5'd3;
    rd_addr1 = 5'd7;
    #1;
    check("dual_p0", rd_data0, 32'h3);
    check("dual_p1", rd_data1, 32'h7);
    rd_addr0 = 5'd7;
    rd_addr1 = 5'd3;
    #1;
    check("swap_p0", rd_data0, 32'h7);
    check("swap_p1", rd_data1, 32'h3);

    // Read-during-write
    wr(5'd9, 32'h1);
`ifdef REGISTER_FILE_BYPASS_EN
    rdw_exp = 32'h2;
`else
    rdw_exp = 32'h1;
`endif
    @(negedge clk);
    wr_ena   = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h2;
    rd_addr0 = 5'd9;
    rd_addr1 = 5'd9;
    #1;
    check("rdw_pre_p0", rd_data0, rdw_exp);
    check("rdw_pre_p1", rd_data1, rdw_exp);
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    #1;
    check("rdw_post_p0", rd_data0, 32'h2);
    check("rdw_post_p1", rd_data1, 32'h2);

    // Reset overrides a simultaneous write
    wr(5'd4, 32'h44);
    @(negedge clk);
    rst      = 1'b0;
    wr_ena   = 1'b1;
    wr_addr  = 5'd4;
    wr_data  = 32'hFF;
    rd_addr0 = 5'd4;
    rd_addr1 = 5'd9;
`ifdef REGISTER_FILE_BYPASS_EN
    #1;
    check("rst_nofwd", rd_data0, 32'h44);
`endif
    @(posedge clk);
    #1;
    rst    = 1'b1;
    wr_ena = 1'b0;
    #1;
    check("rstwr_r4", rd_data0, 32'h0);
    check("rstwr_r9", rd_data1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
